// File: rtl/pipe_adder.sv
// Pipelined segmented carry-chain adder/subtractor with valid/ready handshake.
// Define PIPE_ADDER_FLAGS_EN to add the registered zf/nf result flags.
module pipe_adder #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic             in_cin,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sout,
    output logic             cout,
    output logic             ovf
`ifdef PIPE_ADDER_FLAGS_EN
    ,
    output logic             zf,
    output logic             nf
`endif
);

    localparam int STAGES = WIDTH / SEG_W;
    localparam int LAST   = STAGES - 1;

    // Stage k register set. Operand bits above segment k are still pending;
    // s_q holds segments 0..k already resolved.
    logic             v_q [STAGES];
    logic             c_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             ovf_q;
`ifdef PIPE_ADDER_FLAGS_EN
    logic             zf_q;
    logic             nf_q;
`endif

    logic             v_in [STAGES];
    logic             c_in [STAGES];
    logic [WIDTH-1:0] a_in [STAGES];
    logic [WIDTH-1:0] b_in [STAGES];
    logic [WIDTH-1:0] s_in [STAGES];
    logic [SEG_W:0]   seg  [STAGES];
    logic [WIDTH-1:0] s_nx [STAGES];
    logic             c_nx [STAGES];
    logic             ovf_nx;
    logic             adv;

    // Whole pipe moves in lockstep: a held output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // NOTE: every variable below is assigned on every pass through the block,
    // so no latch can be inferred.
    always_comb begin
        v_in[0] = in_valid;
        c_in[0] = in_sub ? 1'b1 : in_cin;
        a_in[0] = in1;
        b_in[0] = in_sub ? ~in2 : in2;
        s_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k] = v_q[k-1];
            c_in[k] = c_q[k-1];
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            seg[k]  = {1'b0, a_in[k][k*SEG_W +: SEG_W]}
                    + {1'b0, b_in[k][k*SEG_W +: SEG_W]}
                    + {{SEG_W{1'b0}}, c_in[k]};
            s_nx[k] = s_in[k];
            s_nx[k][k*SEG_W +: SEG_W] = seg[k][SEG_W-1:0];
            c_nx[k] = seg[k][SEG_W];
        end
        ovf_nx = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1])
              && (s_nx[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
    end

    // NOTE: state is updated with non-blocking assignments so every stage
    // samples its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data registers are cleared as well, not only valids, so
            // sout/cout/ovf read 0 after reset.
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            ovf_q <= 1'b0;
`ifdef PIPE_ADDER_FLAGS_EN
            zf_q  <= 1'b0;
            nf_q  <= 1'b0;
`endif
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_in[k];
                c_q[k] <= c_nx[k];
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_nx[k];
            end
            ovf_q <= ovf_nx;
`ifdef PIPE_ADDER_FLAGS_EN
            zf_q  <= (s_nx[LAST] == '0);
            nf_q  <= s_nx[LAST][WIDTH-1];
`endif
        end
    end

    assign out_valid = v_q[LAST];
    assign sout      = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;
`ifdef PIPE_ADDER_FLAGS_EN
    assign zf        = zf_q;
    assign nf        = nf_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: 32/8 (4-stage) and 16/16 (1-stage)
// instances against an arithmetic reference model and in-order scoreboard.
module tb_pipe_adder;

    localparam int WA = 32;
    localparam int SA = 8;
    localparam int WB = 16;
    localparam int SB = 16;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    logic          a_in_valid, a_in_ready, a_in_sub, a_in_cin;
    logic [WA-1:0] a_in1, a_in2, a_sout;
    logic          a_out_valid, a_out_ready, a_cout, a_ovf;
    logic          b_in_valid, b_in_ready, b_in_sub, b_in_cin;
    logic [WB-1:0] b_in1, b_in2, b_sout;
    logic          b_out_valid, b_out_ready, b_cout, b_ovf;
`ifdef PIPE_ADDER_FLAGS_EN
    logic          a_zf, a_nf, b_zf, b_nf;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   pops_a   = 0;
    int   pops_b   = 0;
    logic fire_a   = 1'b0;
    logic fire_b   = 1'b0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(WA), .SEG_W(SA)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_sub(a_in_sub), .in_cin(a_in_cin), .in1(a_in1), .in2(a_in2),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .sout(a_sout), .cout(a_cout), .ovf(a_ovf)
`ifdef PIPE_ADDER_FLAGS_EN
        , .zf(a_zf), .nf(a_nf)
`endif
    );

    pipe_adder #(.WIDTH(WB), .SEG_W(SB)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_sub(b_in_sub), .in_cin(b_in_cin), .in1(b_in1), .in2(b_in2),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .sout(b_sout), .cout(b_cout), .ovf(b_ovf)
`ifdef PIPE_ADDER_FLAGS_EN
        , .zf(b_zf), .nf(b_nf)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain w-bit arithmetic, overflow from the true signed sum.
    function automatic exp_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                   input logic sub, input logic cin);
        exp_t        r;
        logic [63:0] mask = (64'd1 << w) - 64'd1;
        logic [63:0] xm   = x & mask;
        logic [63:0] bm   = (sub ? ~y : y) & mask;
        logic        ce   = sub ? 1'b1 : cin;
        logic [64:0] tot  = {1'b0, xm} + {1'b0, bm} + {64'd0, ce};
        longint      sx   = longint'(xm);
        longint      sb   = longint'(bm);
        longint      t;
        longint      lim  = longint'(1) << (w - 1);
        if (xm[w-1]) sx -= longint'(1) << w;
        if (bm[w-1]) sb -= longint'(1) << w;
        t   = sx + sb + longint'(ce);
        r.s = tot[63:0] & mask;
        r.c = tot[w];
        r.v = (t > lim - 1) || (t < -lim);
        r.z = (r.s == 64'd0);
        r.n = r.s[w-1];
        return r;
    endfunction

    // One clock: observe handshakes on the falling edge, then step past the rising edge.
    task automatic tick(output logic acc_a, output logic acc_b);
        exp_t e;
        @(negedge clk);
        acc_a = a_in_valid && a_in_ready;
        acc_b = b_in_valid && b_in_ready;
        if (acc_a) qa.push_back(model(WA, 64'(a_in1), 64'(a_in2), a_in_sub, a_in_cin));
        if (acc_b) qb.push_back(model(WB, 64'(b_in1), 64'(b_in2), b_in_sub, b_in_cin));
        if (a_out_valid && !a_out_ready) check("a_stall_in_ready", 64'(a_in_ready), 64'd0);
        if (b_out_valid && !b_out_ready) check("b_stall_in_ready", 64'(b_in_ready), 64'd0);
        fire_a = a_out_valid && a_out_ready;
        fire_b = b_out_valid && b_out_ready;
        if (fire_a) begin
            pops_a++;
            check("a_beat_expected", 64'(qa.size() != 0), 64'd1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                check("a_sout", 64'(a_sout), e.s);
                check("a_cout", 64'(a_cout), 64'(e.c));
                check("a_ovf", 64'(a_ovf), 64'(e.v));
`ifdef PIPE_ADDER_FLAGS_EN
                check("a_zf", 64'(a_zf), 64'(e.z));
                check("a_nf", 64'(a_nf), 64'(e.n));
`endif
            end
        end
        if (fire_b) begin
            pops_b++;
            check("b_beat_expected", 64'(qb.size() != 0), 64'd1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                check("b_sout", 64'(b_sout), e.s);
                check("b_cout", 64'(b_cout), 64'(e.c));
                check("b_ovf", 64'(b_ovf), 64'(e.v));
`ifdef PIPE_ADDER_FLAGS_EN
                check("b_zf", 64'(b_zf), 64'(e.z));
                check("b_nf", 64'(b_nf), 64'(e.n));
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Single beat into an empty pipe; measures cycles until out_valid.
    task automatic one_beat(input logic sel_b, input logic [31:0] x, input logic [31:0] y,
                            input logic sub, input logic cin, input int exp_lat, input string tag);
        logic aa, ab;
        int   n;
        if (sel_b) begin
            b_in1 = x[15:0]; b_in2 = y[15:0]; b_in_sub = sub; b_in_cin = cin;
            b_in_valid = 1'b1; b_out_ready = 1'b1;
        end else begin
            a_in1 = x; a_in2 = y; a_in_sub = sub; a_in_cin = cin;
            a_in_valid = 1'b1; a_out_ready = 1'b1;
        end
        tick(aa, ab);
        check({tag, "_accept"}, 64'(sel_b ? ab : aa), 64'd1);
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        n = 0;
        do begin
            tick(aa, ab);
            n++;
        end while (!(sel_b ? fire_b : fire_a) && n < 20);
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc_a, acc_b;
        int   sent, cyc, p0;

        acc_a = 1'b0; acc_b = 1'b0;
        rst_n = 1'b1;
        a_in_valid = 1'b0; a_in_sub = 1'b0; a_in_cin = 1'b0; a_in1 = '0; a_in2 = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_sub = 1'b0; b_in_cin = 1'b0; b_in1 = '0; b_in2 = '0; b_out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_sout", 64'(a_sout), 64'd0);
        check("rst_a_cout", 64'(a_cout), 64'd0);
        check("rst_a_ovf", 64'(a_ovf), 64'd0);
        check("rst_a_in_ready", 64'(a_in_ready), 64'd1);
        check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
`ifdef PIPE_ADDER_FLAGS_EN
        check("rst_a_zf", 64'(a_zf), 64'd0);
        check("rst_a_nf", 64'(a_nf), 64'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed arithmetic cases, each with latency measured.
        one_beat(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 4, "carry_seg0_1");
        one_beat(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4, "all_ones_plus1");
        one_beat(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4, "pos_overflow");
        one_beat(1'b0, 32'd5,         32'd7,         1'b1, 1'b0, 4, "sub_borrow");
        one_beat(1'b0, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 4, "sub_equal");
        one_beat(1'b0, 32'h00FF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 4, "cin_ripple");
        one_beat(1'b1, 32'h0000_8000, 32'h0000_8000, 1'b0, 1'b0, 1, "w16_neg_ovf");
        one_beat(1'b1, 32'h0000_0003, 32'h0000_0009, 1'b1, 1'b0, 1, "w16_sub");

        // Eight back-to-back beats with the consumer stalled for cycles 6..10.
        p0 = pops_a; sent = 0; cyc = 0;
        while ((sent < 8 || qa.size() != 0) && cyc < 60) begin
            a_in_valid  = (sent < 8);
            a_in1       = 32'(sent);
            a_in2       = 32'(sent);
            a_in_sub    = 1'b0;
            a_in_cin    = 1'b0;
            a_out_ready = !(cyc >= 6 && cyc <= 10);
            tick(acc_a, acc_b);
            if (acc_a) sent++;
            cyc++;
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        check("stream_beats_out", 64'(pops_a - p0), 64'd8);
        check("stream_drained", 64'(qa.size()), 64'd0);

        // Randomised traffic with random backpressure on both instances.
        acc_a = 1'b0; acc_b = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (!a_in_valid || acc_a) begin
                a_in_valid = ($urandom_range(0, 3) != 0);
                a_in1 = $urandom; a_in2 = $urandom;
                if ($urandom_range(0, 7) == 0) a_in1 = 32'hFFFF_FFFF;
                a_in_sub = $urandom_range(0, 1); a_in_cin = $urandom_range(0, 1);
            end
            if (!b_in_valid || acc_b) begin
                b_in_valid = ($urandom_range(0, 3) != 0);
                b_in1 = 16'($urandom); b_in2 = 16'($urandom);
                b_in_sub = $urandom_range(0, 1); b_in_cin = $urandom_range(0, 1);
            end
            a_out_ready = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 2) != 0);
            tick(acc_a, acc_b);
        end
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        for (int n = 0; n < 20 && (qa.size() != 0 || qb.size() != 0); n++) tick(acc_a, acc_b);
        check("rand_a_drained", 64'(qa.size()), 64'd0);
        check("rand_b_drained", 64'(qb.size()), 64'd0);

        // Reset with the pipe full; nothing from before reset may reappear.
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1; a_in1 = 32'(100 + i); a_in2 = 32'(i); a_in_sub = 1'b0;
            tick(acc_a, acc_b);
        end
        a_in_valid = 1'b0;
        check("pre_rst_out_valid", 64'(a_out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
        check("mid_rst_sout", 64'(a_sout), 64'd0);
        qa.delete();
        qb.delete();
        tick(acc_a, acc_b);
        tick(acc_a, acc_b);
        rst_n = 1'b1;
        p0 = pops_a;
        for (int i = 0; i < 8; i++) tick(acc_a, acc_b);
        check("no_stale_beat", 64'(pops_a - p0), 64'd0);
        one_beat(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 4, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
Parametrised, pipelined carry-chain adder/subtractor, successor to the fixed 32-bit two-segment adder. Operand width is split into WIDTH/SEG_W segments. Each pipeline stage resolves one segment and registers the carry into the next stage. A valid/ready handshake with full-pipe backpressure lets the block sit between the ALU issue logic and writeback in the NPC datapath.

Parameters:
WIDTH, 32, operand and result width in bits; must be a multiple of SEG_W.
SEG_W, 8, segment width per stage; STAGES = WIDTH/SEG_W (SEG_W == WIDTH gives a 1-stage adder).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand beat valid.
in_ready  output  1  block can accept a beat this cycle.
in_sub  input  1  0 = in1+in2+in_cin, 1 = in1-in2 (in1 + ~in2 + 1; in_cin ignored).
in_cin  input  1  carry-in for add mode.
in1  input  WIDTH  operand A.
in2  input  WIDTH  operand B.
out_valid  output  1  result beat valid.
out_ready  input  1  consumer accepts the result.
sout  output  WIDTH  sum/difference, modulo 2^WIDTH.
cout  output  1  carry out of bit WIDTH-1 (sub: 1 = no borrow).
ovf  output  1  signed overflow.

Behaviour:
- Reset (async assert, sync release via clk): all stage valid bits, out_valid, sout, cout, ovf = 0. Data registers clear to 0. Reset mid-operation discards every in-flight beat. No output beat is produced from pre-reset data.
- Handshake:
  - Transfer in when in_valid && in_ready.
  - Transfer out when out_valid && out_ready.
  - Inputs and outputs must stay stable while valid && !ready.
- Stall rule: adv = !out_valid || out_ready.
  - in_ready = adv, purely combinational from out_valid/out_ready, not from in_valid.
  - When adv = 0 every stage holds. When adv = 1 every stage shifts one position. Bubbles are not compressed.
- Latency: exactly STAGES cycles from an accepted input to out_valid when unstalled. Throughput is 1 beat/cycle.
- Stage k (0-based) adds segment k using:
  - b' = in2 (add) or ~in2 (sub);
  - carry-in = stage k-1 registered carry; stage 0 uses in_sub ? 1 : in_cin.
- Segments above k travel as skewed operand registers. Finished low segments travel as result registers.
- Final stage drives sout, cout, and ovf = (a[W-1] == b'[W-1]) && (sout[W-1] != a[W-1]).
- Boundaries:
  - All-ones + 1 gives sout = 0, cout = 1.
  - Sub with equal operands gives sout = 0, cout = 1.
  - Stall with full pipe: in_ready = 0 and no beat lost or duplicated.
  - Simultaneous in/out transfer while full is allowed (adv = 1).

Optional Feature:
Macro PIPE_ADDER_FLAGS_EN.
- Defined: adds output ports zf (1, sout == 0) and nf (1, sout[WIDTH-1]). Both are registered with the final stage, reset to 0, and valid with out_valid.
- Undefined: zf/nf ports and their logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=32, SEG_W=8, out_ready=1: in1=0x0000_00FF, in2=0x0000_0001, add, cin=0 -> after 4 cycles sout=0x0000_0100, cout=0, ovf=0; carry crosses stage 0→1.
- in1=0xFFFF_FFFF, in2=0x0000_0001, add -> sout=0, cout=1, ovf=0; with FLAGS_EN, zf=1, nf=0.
- in1=0x7FFF_FFFF, in2=0x0000_0001, add -> sout=0x8000_0000, ovf=1, cout=0; in1=5, in2=7, sub -> sout=0xFFFF_FFFE, cout=0 (borrow), ovf=0.
- Stream 8 back-to-back beats (in1=i, in2=i), hold out_ready=0 from cycle 6 to 10:
  - in_ready drops the same cycle out_valid=1 && out_ready=0;
  - all 8 results 2i emerge in order, none dropped or duplicated.
- Assert rst_n low mid-stream with 3 beats in flight -> out_valid=0 immediately; after release, no stale beat appears and the next accepted beat has latency 4.
- WIDTH=16, SEG_W=16: in1=0x8000, in2=0x8000 add -> latency 1, sout=0x0000, cout=1, ovf=1.
